store_buffer: RTL

- Sits directly downstream of the load/store unit.
- Accepts executed store requests (type data_memreq_t) and holds them in program order until the reorder buffer commits them.
- Drains committed stores one at a time onto the dbus write port.
- Lets the load path check whether a pending store overlaps a load address, so that load can be held back.

---
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer.sv | 91 +++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Store request type and the push/drain handshake bundle between LSU, store buffer and dbus.
// Pure wiring; the store buffer uses the slave view, the LSU/dbus side the master view.
package store_buffer_pkg;
   typedef struct packed {
      logic        read;
      logic        write;
      logic        invalidate;
      logic        invalidate_icache;
      logic        uncached;
      logic [31:0] paddr;
      logic [31:0] vaddr;
      logic [31:0] wrdata;
      logic [3:0]  byteenable;
   } data_memreq_t;
endpackage

interface store_buffer_if;
   import store_buffer_pkg::*;

   logic         push_valid;
   data_memreq_t push_req;
   logic         push_ready;
   logic         dbus_request;
   data_memreq_t dbus_req;
   logic         dbus_ready;

   modport slave  (input  push_valid, push_req, dbus_ready,
                   output push_ready, dbus_request, dbus_req);
   modport master (output push_valid, push_req, dbus_ready,
                   input  push_ready, dbus_request, dbus_req);
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: holds stores until ROB commit, drains one per cycle to dbus (1-cycle commit-to-drain).
// push_ready/dbus_request come from registered pointers only; a full buffer stalls the LSU until a pop retires.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   commit,
   store_buffer_if.slave          sb,
   input  logic [31:0]            lookup_paddr,
   input  logic [3:0]             lookup_byteenable,
   output logic                   lookup_hit,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] uncommitted_cnt
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] head_q, head_d;
   logic [PTR_W:0] cptr_q, cptr_d;
   logic [PTR_W:0] tail_q, tail_d;
   data_memreq_t   mem_q [DEPTH];

   logic [PTR_W:0] committed;
   logic [PTR_W:0] total;
   logic           do_push;
   logic           do_commit;
   logic           do_pop;
   logic [DEPTH-1:0] hit_vec;

   assign committed       = cptr_q - head_q;
   assign total           = tail_q - head_q;
   assign uncommitted_cnt = tail_q - cptr_q;

   assign sb.push_ready   = (total != (PTR_W+1)'(DEPTH));
   assign sb.dbus_request = (committed != '0);
   assign empty           = (total == '0);

   assign do_push   = sb.push_valid & sb.push_ready & ~flush;
   assign do_commit = commit & (uncommitted_cnt != '0);
   assign do_pop    = sb.dbus_request & sb.dbus_ready;

   always_comb begin
      head_d = head_q + {{PTR_W{1'b0}}, do_pop};
      cptr_d = cptr_q + {{PTR_W{1'b0}}, do_commit};
      tail_d = tail_q + {{PTR_W{1'b0}}, do_push};
      // Flush discards only what the ROB has not retired, including a same-cycle commit.
      if (flush) begin
         tail_d = cptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         cptr_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         cptr_q <= cptr_d;
         tail_q <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[tail_q[PTR_W-1:0]] <= sb.push_req;
      end
   end

   always_comb begin
      sb.dbus_req                   = mem_q[head_q[PTR_W-1:0]];
      sb.dbus_req.read              = 1'b0;
      sb.dbus_req.write             = 1'b1;
      sb.dbus_req.invalidate        = 1'b0;
      sb.dbus_req.invalidate_icache = 1'b0;
   end

   // An entry is live when its distance from head is below the occupancy.
   for (genvar g = 0; g < DEPTH; g++) begin : g_hit
      logic [PTR_W-1:0] off;
      assign off        = PTR_W'(g) - head_q[PTR_W-1:0];
      assign hit_vec[g] = ({1'b0, off} < total)
                        && (mem_q[g].paddr[31:2] == lookup_paddr[31:2])
                        && (|(mem_q[g].byteenable & lookup_byteenable));
   end

   assign lookup_hit = |hit_vec;
endmodule
